// File: rtl/multi_share_arbiter.sv
// multi_share_arbiter
// Shares a single 8x8 multiplier (low byte of the product) among NREQ
// requesters. Round-robin grant, valid/ready handshake on both sides,
// registered operands and result, result tagged with the owner's index.
module multi_share_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  output logic [ID_W-1:0]   rsp_id,
  output logic [7:0]        rsp_data,
  input  logic              rsp_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Shared multiplier: only the low byte of the product is kept.
  function automatic logic [7:0] mul_low8(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] prod;
    prod = {8'd0, a} * {8'd0, b};
    return prod[7:0];
  endfunction

  state_t          state_r;
  logic [ID_W-1:0] ptr_r;
  logic [ID_W-1:0] id_r;
  logic [7:0]      a_r;
  logic [7:0]      b_r;
  logic            rsp_valid_r;
  logic [ID_W-1:0] rsp_id_r;
  logic [7:0]      rsp_data_r;

  logic            grant_en_s;
  logic            pick_found_s;
  logic [ID_W-1:0] pick_id_s;
  logic            xfer_s;
  int              idx_s;

  // Round-robin search: first valid requester after the pointer, wrapping.
  always_comb begin
    pick_found_s = 1'b0;
    pick_id_s    = '0;
    idx_s        = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx_s = (int'(ptr_r) + k) % NREQ;
      if (!pick_found_s && req_valid[idx_s]) begin
        pick_found_s = 1'b1;
        pick_id_s    = ID_W'(idx_s);
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  // Grants may be issued when idle, or while the result leaves this cycle.
  always_comb begin
    grant_en_s = 1'b0;
    case (state_r)
      IDLE:    grant_en_s = 1'b1;
      RESP:    grant_en_s = rsp_ready;
      default: grant_en_s = 1'b0;
    endcase
  end

  // A granted requester is always valid, so a grant is itself a transfer.
  assign xfer_s = grant_en_s & pick_found_s & rst_n;

  // One-hot ready towards the chosen requester; held low during reset.
  always_comb begin
    req_ready = '0;
    if (xfer_s) begin
      req_ready = {{(NREQ-1){1'b0}}, 1'b1} << pick_id_s;
    end else begin
      req_ready = '0;
    end
  end

  // Main FSM: latch operands on transfer, compute, then hold the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      ptr_r       <= ID_W'(NREQ - 1);
      id_r        <= '0;
      a_r         <= 8'd0;
      b_r         <= 8'd0;
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= '0;
      rsp_data_r  <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (xfer_s) begin
            a_r     <= req_a[8*pick_id_s +: 8];
            b_r     <= req_b[8*pick_id_s +: 8];
            id_r    <= pick_id_s;
            ptr_r   <= pick_id_s;
            state_r <= CALC;
          end
        end
        CALC: begin
          rsp_data_r  <= mul_low8(a_r, b_r);
          rsp_id_r    <= id_r;
          rsp_valid_r <= 1'b1;
          state_r     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            if (xfer_s) begin
              a_r     <= req_a[8*pick_id_s +: 8];
              b_r     <= req_b[8*pick_id_s +: 8];
              id_r    <= pick_id_s;
              ptr_r   <= pick_id_s;
              state_r <= CALC;
            end else begin
              state_r <= IDLE;
            end
          end
        end
        default: begin
          state_r     <= IDLE;
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_id    = rsp_id_r;
  assign rsp_data  = rsp_data_r;

endmodule

// File: tb/tb_multi_share_arbiter.sv
// Testbench for multi_share_arbiter: table of single transactions, directed
// corner sequences (fairness, backpressure, resets), then random traffic
// against a transaction-level reference model.
module tb_multi_share_arbiter;

  localparam int NREQ = 4;
  localparam int ID_W = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [8*NREQ-1:0] req_a = '0;
  logic [8*NREQ-1:0] req_b = '0;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic [ID_W-1:0]   rsp_id;
  logic [7:0]        rsp_data;
  logic              rsp_ready = 1'b0;

  multi_share_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0] valid;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] exp_ready;
    logic [1:0] exp_id;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_all(input logic [7:0] a, input logic [7:0] b);
    for (int i = 0; i < NREQ; i++) begin
      req_a[8*i +: 8] = a;
      req_b[8*i +: 8] = b;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // reference model state (transaction level)
  int m_last;
  bit m_job;
  int m_job_id;
  int m_job_data;
  bit m_res;
  int m_id;
  int m_data;

  initial begin
    int pick;
    int idx;
    logic [3:0] exp_ready;

    vecs[0] = '{4'b0100, 8'd3,   8'd5,   4'b0100, 2'd2, 8'd15};
    vecs[1] = '{4'b0001, 8'd20,  8'd20,  4'b0001, 2'd0, 8'h90};
    vecs[2] = '{4'b1000, 8'd255, 8'd255, 4'b1000, 2'd3, 8'h01};
    vecs[3] = '{4'b0010, 8'd0,   8'd200, 4'b0010, 2'd1, 8'h00};
    vecs[4] = '{4'b0101, 8'd7,   8'd9,   4'b0100, 2'd2, 8'd63};
    vecs[5] = '{4'b0011, 8'd16,  8'd17,  4'b0001, 2'd0, 8'd16};
    vecs[6] = '{4'b1111, 8'd200, 8'd3,   4'b0010, 2'd1, 8'd88};

    // reset state, with all requesters asking
    req_valid = 4'hF;
    #2;
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rsp_id", {30'd0, rsp_id}, 32'd0);
    chk("reset_rsp_data", {24'd0, rsp_data}, 32'd0);
    chk("reset_req_ready", {28'd0, req_ready}, 32'd0);
    do_reset();

    // table of single transactions
    for (int v = 0; v < 7; v++) begin
      @(negedge clk);
      req_valid = vecs[v].valid;
      set_all(vecs[v].a, vecs[v].b);
      rsp_ready = 1'b0;
      #1;
      chk("tbl_grant", {28'd0, req_ready}, {28'd0, vecs[v].exp_ready});
      @(negedge clk);
      req_valid = 4'hF;
      #1;
      chk("tbl_calc_ready", {28'd0, req_ready}, 32'd0);
      chk("tbl_calc_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);
      #1;
      chk("tbl_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("tbl_rsp_id", {30'd0, rsp_id}, {30'd0, vecs[v].exp_id});
      chk("tbl_rsp_data", {24'd0, rsp_data}, {24'd0, vecs[v].exp_data});
      chk("tbl_resp_hold_ready", {28'd0, req_ready}, 32'd0);
      req_valid = '0;
      rsp_ready = 1'b1;
      @(negedge clk);
      #1;
      chk("tbl_rsp_drop", {31'd0, rsp_valid}, 32'd0);
      rsp_ready = 1'b0;
    end

    // fairness: all valid, result always accepted
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_a[8*i +: 8] = 8'(i + 1);
      req_b[8*i +: 8] = 8'(10 + i);
    end
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    #1;
    chk("fair_first_grant", {28'd0, req_ready}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("fair_calc_ready", {28'd0, req_ready}, 32'd0);
      @(negedge clk);
      #1;
      chk("fair_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("fair_rsp_id", {30'd0, rsp_id}, 32'(i % 4));
      chk("fair_rsp_data", {24'd0, rsp_data}, 32'((((i % 4) + 1) * (10 + (i % 4))) % 256));
      chk("fair_next_grant", {28'd0, req_ready}, 32'(1 << ((i + 1) % 4)));
    end

    // backpressure: requester 1 in flight, hold its result 5 cycles
    @(negedge clk);
    rsp_ready = 1'b0;
    @(negedge clk);
    #1;
    for (int c = 0; c < 5; c++) begin
      chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_rsp_id", {30'd0, rsp_id}, 32'd1);
      chk("bp_rsp_data", {24'd0, rsp_data}, 32'd22);
      chk("bp_ready_low", {28'd0, req_ready}, 32'd0);
      @(negedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_grant", {28'd0, req_ready}, 32'b0100);
    @(negedge clk);
    req_valid = '0;
    rsp_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("bp_next_id", {30'd0, rsp_id}, 32'd2);

    // asynchronous reset while a result is held
    req_valid = 4'hF;
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midrst_rsp_id", {30'd0, rsp_id}, 32'd0);
    chk("midrst_rsp_data", {24'd0, rsp_data}, 32'd0);
    chk("midrst_req_ready", {28'd0, req_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = '0;

    // reset during CALC drops the operation; pointer back to start
    @(negedge clk);
    req_valid = 4'b0010;
    set_all(8'd9, 8'd9);
    rsp_ready = 1'b1;
    #1;
    chk("rcalc_grant", {28'd0, req_ready}, 32'b0010);
    @(negedge clk);
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    chk("rcalc_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk("rcalc_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    req_valid = 4'b0011;
    #1;
    chk("rcalc_grant0_first", {28'd0, req_ready}, 32'b0001);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);

    // random traffic against the reference model
    do_reset();
    m_last = NREQ - 1;
    m_job = 1'b0;
    m_res = 1'b0;
    m_job_id = 0;
    m_job_data = 0;
    m_id = 0;
    m_data = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      req_valid = 4'($urandom_range(0, 15));
      req_a = $urandom();
      req_b = $urandom();
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      pick = -1;
      if (!m_job && (!m_res || rsp_ready)) begin
        for (int off = 1; off <= NREQ; off++) begin
          idx = (m_last + off) % NREQ;
          if (pick < 0 && req_valid[idx]) pick = idx;
        end
      end
      exp_ready = (pick >= 0) ? 4'(1 << pick) : 4'd0;
      chk("rnd_req_ready", {28'd0, req_ready}, {28'd0, exp_ready});
      chk("rnd_rsp_valid", {31'd0, rsp_valid}, {31'd0, m_res});
      if (m_res) begin
        chk("rnd_rsp_id", {30'd0, rsp_id}, 32'(m_id));
        chk("rnd_rsp_data", {24'd0, rsp_data}, 32'(m_data));
      end
      if (m_res && rsp_ready) m_res = 1'b0;
      if (m_job) begin
        m_res = 1'b1;
        m_id = m_job_id;
        m_data = m_job_data;
        m_job = 1'b0;
      end
      if (pick >= 0) begin
        m_job = 1'b1;
        m_job_id = pick;
        m_job_data = (int'(req_a[8*pick +: 8]) * int'(req_b[8*pick +: 8])) % 256;
        m_last = pick;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
